// File: rtl/alu_exec_stage.sv
// Single-issue ALU execute stage with valid/ready handshakes on both sides.
// Non-MUL ops finish in one cycle; MUL runs a 16-step shift-add sequence.
module alu_exec_stage #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi,
  output logic [3:0]       flags,
  output logic             illegal
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MULT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;

  logic [1:0]       state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [CNT_W-1:0] cnt;

  logic             accept;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_lo;
  logic             alu_c;
  logic             alu_v;
  logic             alu_ill;

  logic [WIDTH:0]   step_sum;
  logic [WIDTH-1:0] next_hi;
  logic [WIDTH-1:0] next_lo;

  assign out_valid = (state == S_HOLD);
  assign in_ready  = (state == S_IDLE) || ((state == S_HOLD) && out_ready);
  assign accept    = in_valid && in_ready;

  // SUB reuses the adder as opa + ~opb + 1, so carry-out means "no borrow".
  assign add_b = (op == OP_SUB) ? ~opb : opb;
  assign sum   = {1'b0, opa} + {1'b0, add_b} + {{WIDTH{1'b0}}, (op == OP_SUB)};

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    alu_lo  = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ill = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        alu_lo = sum[WIDTH-1:0];
        alu_c  = sum[WIDTH];
        alu_v  = (opa[WIDTH-1] == add_b[WIDTH-1]) && (sum[WIDTH-1] != opa[WIDTH-1]);
      end
      OP_AND: alu_lo = opa & opb;
      OP_OR:  alu_lo = opa | opb;
      OP_XOR: alu_lo = opa ^ opb;
      OP_MUL: alu_lo = '0;
      default: alu_ill = 1'b1;
    endcase
  end

  // One shift-add step: conditionally add the multiplicand into the high half,
  // then shift the 33-bit {carry, high, low} right by one.
  assign step_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
  assign next_hi  = step_sum[WIDTH:1];
  assign next_lo  = {step_sum[0], acc_lo[WIDTH-1:1]};

  // NOTE: state registers use non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      mcand   <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      cnt     <= '0;
      res_lo  <= '0;
      res_hi  <= '0;
      flags   <= '0;
      illegal <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_HOLD: begin
          if (accept) begin
            if (op == OP_MUL) begin
              state  <= S_MULT;
              mcand  <= opb;
              acc_hi <= '0;
              acc_lo <= opa;
              cnt    <= '0;
            end else begin
              state   <= S_HOLD;
              res_lo  <= alu_lo;
              res_hi  <= '0;
              flags   <= {alu_lo[WIDTH-1], (alu_lo == '0), alu_c, alu_v};
              illegal <= alu_ill;
            end
          end else if (state == S_HOLD && out_ready) begin
            state <= S_IDLE;
          end
        end
        S_MULT: begin
          acc_hi <= next_hi;
          acc_lo <= next_lo;
          cnt    <= cnt + 1'b1;
          // The last step's result is published directly, saving a cycle.
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state   <= S_HOLD;
            res_lo  <= next_lo;
            res_hi  <= next_hi;
            flags   <= {next_lo[WIDTH-1], ({next_hi, next_lo} == '0), (next_hi != '0), 1'b0};
            illegal <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: directed corner cases plus random
// operations compared against an arithmetic reference model.
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [15:0] opa;
  logic [15:0] opb;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] res_lo;
  logic [15:0] res_hi;
  logic [3:0]  flags;
  logic        illegal;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_exec_stage #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .opa       (opa),
    .opb       (opb),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res_lo    (res_lo),
    .res_hi    (res_hi),
    .flags     (flags),
    .illegal   (illegal)
  );

  typedef struct {
    logic [15:0] lo;
    logic [15:0] hi;
    logic [3:0]  fl;
    logic        ill;
    int          lat;
  } exp_t;

  // Reference model: plain integer arithmetic, signed range test for overflow.
  function automatic exp_t model(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
    exp_t   e;
    longint ua;
    longint ub;
    longint p;
    int     sa;
    int     sb;
    int     s;
    logic   c;
    logic   v;
    logic   z;
    ua = a; ub = b; p = 0;
    sa = $signed(a); sb = $signed(b);
    c = 1'b0; v = 1'b0;
    e.hi = 16'h0; e.ill = 1'b0; e.lat = 1;
    case (o)
      3'd0: begin
        p = ua + ub; e.lo = p[15:0]; c = (p > 65535);
        s = sa + sb; v = (s > 32767) || (s < -32768);
      end
      3'd1: begin
        p = ua - ub; e.lo = p[15:0]; c = (ua >= ub);
        s = sa - sb; v = (s > 32767) || (s < -32768);
      end
      3'd2: e.lo = a & b;
      3'd3: e.lo = a | b;
      3'd4: e.lo = a ^ b;
      3'd5: begin
        p = ua * ub; e.lo = p[15:0]; e.hi = p[31:16];
        c = (e.hi != 16'h0); e.lat = 17;
      end
      default: begin
        e.lo = 16'h0; e.ill = 1'b1;
      end
    endcase
    z = (o == 3'd5) ? (p == 0) : (e.lo == 16'h0);
    e.fl = {e.lo[15], z, c, v};
    return e;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_result(input string tag, input exp_t e);
    check({tag, ".out_valid"}, 32'(out_valid), 32'(1'b1));
    check({tag, ".res_lo"},    32'(res_lo),    32'(e.lo));
    check({tag, ".res_hi"},    32'(res_hi),    32'(e.hi));
    check({tag, ".flags"},     32'(flags),     32'(e.fl));
    check({tag, ".illegal"},   32'(illegal),   32'(e.ill));
  endtask

  // One transaction from IDLE; operands are scrambled while busy or holding.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [15:0] a,
                        input logic [15:0] b, input int hold);
    exp_t e;
    e = model(o, a, b);
    in_valid = 1'b1; op = o; opa = a; opb = b; out_ready = (hold == 0);
    #1;
    check({tag, ".accept_ready"}, 32'(in_ready), 32'(1'b1));
    tick();
    in_valid = 1'b0;
    for (int i = 1; i < e.lat; i++) begin
      check({tag, ".busy_valid"}, 32'(out_valid), 32'(1'b0));
      check({tag, ".busy_ready"}, 32'(in_ready), 32'(1'b0));
      opa = 16'($urandom); opb = 16'($urandom); op = 3'($urandom);
      tick();
    end
    check_result(tag, e);
    for (int i = 0; i < hold; i++) begin
      opa = 16'($urandom); opb = 16'($urandom); op = 3'($urandom);
      tick();
      check_result({tag, ".held"}, e);
    end
    out_ready = 1'b1;
    #1;
    check({tag, ".hold_ready"}, 32'(in_ready), 32'(1'b1));
    tick();
    check({tag, ".retired"}, 32'(out_valid), 32'(1'b0));
  endtask

  initial begin
    exp_t        prev;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  o;
    logic        seen;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 3'd0; opa = 16'h0; opb = 16'h0;
    repeat (3) tick();
    check("reset.out_valid", 32'(out_valid), 32'(1'b0));
    check("reset.in_ready",  32'(in_ready),  32'(1'b1));
    check("reset.res_lo",    32'(res_lo),    32'h0);
    check("reset.res_hi",    32'(res_hi),    32'h0);
    check("reset.flags",     32'(flags),     32'h0);
    check("reset.illegal",   32'(illegal),   32'h0);
    rst = 1'b0;
    tick();

    // Directed corner cases.
    run_op("add_wrap",  3'd0, 16'hFFFF, 16'h0001, 0);
    check("add_wrap.flags_const", 32'(flags), 32'(4'b0110));
    run_op("add_ovf",   3'd0, 16'h7FFF, 16'h0001, 0);
    check("add_ovf.flags_const", 32'(flags), 32'(4'b1001));
    run_op("sub_borrow", 3'd1, 16'h0003, 16'h0005, 0);
    check("sub_borrow.lo_const", 32'(res_lo), 32'hFFFE);
    check("sub_borrow.flags_const", 32'(flags), 32'(4'b1000));
    run_op("mul_max",   3'd5, 16'hFFFF, 16'hFFFF, 0);
    check("mul_max.hi_const", 32'(res_hi), 32'hFFFE);
    check("mul_max.lo_const", 32'(res_lo), 32'h0001);
    check("mul_max.flags_const", 32'(flags), 32'(4'b0010));
    run_op("xor_hold",  3'd4, 16'hA5A5, 16'hFFFF, 5);
    check("xor_hold.lo_const", 32'(res_lo), 32'h5A5A);

    // Back-to-back ADDs, one result per cycle, ending with an illegal op.
    in_valid = 1'b1; out_ready = 1'b1;
    a = 16'($urandom); b = 16'($urandom);
    op = 3'd0; opa = a; opb = b; prev = model(3'd0, a, b);
    tick();
    for (int k = 0; k < 7; k++) begin
      check_result("b2b", prev);
      check("b2b.in_ready", 32'(in_ready), 32'(1'b1));
      o = (k == 6) ? 3'b111 : 3'd0;
      a = 16'($urandom); b = 16'($urandom);
      op = o; opa = a; opb = b; prev = model(o, a, b);
      tick();
    end
    in_valid = 1'b0;
    check_result("illegal", prev);
    check("illegal.flag_const", 32'(illegal), 32'(1'b1));
    check("illegal.flags_const", 32'(flags), 32'(4'b0100));
    tick();
    check("illegal.retired", 32'(out_valid), 32'(1'b0));

    // Random operations with random downstream back-pressure.
    for (int n = 0; n < 24; n++) begin
      run_op("rand", 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), $urandom_range(0, 2));
    end

    // Reset wins over an accept in the same cycle.
    rst = 1'b1; in_valid = 1'b1; op = 3'd0; opa = 16'h1234; opb = 16'h1111; out_ready = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    check("rst_accept.out_valid", 32'(out_valid), 32'(1'b0));
    tick();
    check("rst_accept.dropped", 32'(out_valid), 32'(1'b0));

    // Give the result registers something nonzero, then reset mid-MUL.
    run_op("pre_abort", 3'd3, 16'hF00F, 16'h0FF0, 0);
    in_valid = 1'b1; op = 3'd5; opa = 16'h1234; opb = 16'h5678;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    check("abort.busy", 32'(out_valid), 32'(1'b0));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort.out_valid", 32'(out_valid), 32'(1'b0));
    check("abort.in_ready",  32'(in_ready),  32'(1'b1));
    check("abort.res_lo",    32'(res_lo),    32'h0);
    check("abort.res_hi",    32'(res_hi),    32'h0);
    check("abort.flags",     32'(flags),     32'h0);
    check("abort.illegal",   32'(illegal),   32'h0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    check("abort.no_pulse", 32'(seen), 32'(1'b0));
    run_op("post_abort", 3'd1, 16'h8000, 16'h0001, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
